// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM state encoding and counter sizing.
package serial_adder_pkg;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result bundle between the operand source, the serial adder and the result consumer.
// ovf_o only exists when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(parameter int WIDTH = 8);
  logic             start_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             cin_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] sum_o;
  logic             cout_o;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_o;

  modport master (output start_i, a_i, b_i, cin_i,
                  input  busy_o, done_o, sum_o, cout_o, ovf_o);
  modport slave  (input  start_i, a_i, b_i, cin_i,
                  output busy_o, done_o, sum_o, cout_o, ovf_o);
`else
  modport master (output start_i, a_i, b_i, cin_i,
                  input  busy_o, done_o, sum_o, cout_o);
  modport slave  (input  start_i, a_i, b_i, cin_i,
                  output busy_o, done_o, sum_o, cout_o);
`endif
endinterface

// File: rtl/serial_adder_fa_bit.sv
// Single combinational full-adder cell shared by every bit position of the serial adder.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB-first, result after WIDTH run cycles.
// Optional SERIAL_ADDER_OVF_EN adds a two's-complement overflow flag (ovf_o).
//
// state | meaning
// IDLE  | waiting for start_i; operands captured on the accepting edge
// RUN   | one bit per clock through fa_bit, WIDTH cycles
// DONE  | single cycle, done_o high, sum_o/cout_o valid
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  serial_adder_if.slave bus
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_next;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             cout_q;
  logic             s_bit;
  logic             c_bit;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q;
`endif

  fa_bit u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (s_bit),
    .cout (c_bit)
  );

  // new bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts
  assign sum_next = {s_bit, {(WIDTH-1){1'b0}}} | (sum_sh >> 1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      sum_q  <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            a_sh  <= bus.a_i;
            b_sh  <= bus.b_i;
            carry <= bus.cin_i;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_sh <= sum_next;
          carry  <= c_bit;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          if (cnt == LAST) begin
            state  <= DONE;
            sum_q  <= sum_next;
            cout_q <= c_bit;
`ifdef SERIAL_ADDER_OVF_EN
            // carry still holds the carry into the MSB on this edge
            ovf_q  <= carry ^ c_bit;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy_o = (state == RUN) || (state == DONE);
  assign bus.done_o = (state == DONE);
  assign bus.sum_o  = sum_q;
  assign bus.cout_o = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.ovf_o  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Randomized and directed bench for serial_adder at WIDTH=8 and WIDTH=32 against an arithmetic model.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [32:0] prev8;
  logic [32:0] prev32;

  serial_adder_if #(.WIDTH(8))  bus8 ();
  serial_adder_if #(.WIDTH(32)) bus32 ();

  serial_adder #(.WIDTH(8))  dut8  (.clk_i(clk), .rst_i(rst), .bus(bus8));
  serial_adder #(.WIDTH(32)) dut32 (.clk_i(clk), .rst_i(rst), .bus(bus32));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive(input bit wide, input logic st, input logic [31:0] a, input logic [31:0] b,
                       input logic c);
    if (wide) begin
      bus32.start_i = st; bus32.a_i = a; bus32.b_i = b; bus32.cin_i = c;
    end else begin
      bus8.start_i = st; bus8.a_i = a[7:0]; bus8.b_i = b[7:0]; bus8.cin_i = c;
    end
  endtask

  task automatic sample(input bit wide, output logic d, output logic bz, output logic [32:0] r);
    if (wide) begin
      d = bus32.done_o; bz = bus32.busy_o; r = {bus32.cout_o, bus32.sum_o};
    end else begin
      d = bus8.done_o; bz = bus8.busy_o; r = {24'b0, bus8.cout_o, bus8.sum_o};
    end
  endtask

  task automatic garble(input bit wide);
    logic cr;
    cr = 1'($urandom_range(0, 1));
    drive(wide, 1'b0, $urandom, $urandom, cr);
  endtask

  // One operation: start, check latency, busy span, result hold, result, and single done pulse.
  task automatic run_op(input bit wide, input logic [31:0] a_in, input logic [31:0] b_in,
                        input logic c, input bit poke);
    int          w, cyc, busy_n, hold_bad;
    logic [63:0] mask, av, bv, exp;
    logic [32:0] prev, r;
    logic        d, bz, acc;
    longint      sa, sb, ss, lim;
    logic        exp_ov;
    w    = wide ? 32 : 8;
    mask = (64'd1 << w) - 1;
    av   = {32'b0, a_in} & mask;
    bv   = {32'b0, b_in} & mask;
    exp  = av + bv + {63'b0, c};
    lim  = longint'(64'd1 << (w - 1));
    sa   = (av >= (64'd1 << (w - 1))) ? longint'(av) - 2 * lim : longint'(av);
    sb   = (bv >= (64'd1 << (w - 1))) ? longint'(bv) - 2 * lim : longint'(bv);
    ss   = sa + sb + longint'(c);
    exp_ov = (ss > lim - 1) || (ss < -lim);
    prev = wide ? prev32 : prev8;
    hold_bad = 0;

    @(negedge clk);
    drive(wide, 1'b1, a_in, b_in, c);
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(posedge clk); #1;
      sample(wide, d, bz, r);
      acc = bz;
      if (r !== prev) hold_bad++;
    end
    if (!acc) begin
      chk("accept_timeout", 64'd0, 64'd1);
      garble(wide);
      return;
    end
    garble(wide);

    busy_n = 1;
    cyc    = 0;
    d      = 1'b0;
    while (cyc < w + 20 && !d) begin
      if (poke && (cyc == 2 || cyc == 3)) drive(wide, 1'b1, 32'hAA, 32'hAA, 1'b1);
      else garble(wide);
      @(posedge clk); #1;
      cyc++;
      sample(wide, d, bz, r);
      if (bz) busy_n++;
      if (!d && r !== prev) hold_bad++;
    end
    garble(wide);
    chk("latency", 64'(cyc), 64'(w));
    chk("result", {31'b0, r}, exp);
`ifdef SERIAL_ADDER_OVF_EN
    chk("ovf", {63'b0, (wide ? bus32.ovf_o : bus8.ovf_o)}, {63'b0, exp_ov});
`endif
    @(posedge clk); #1;
    sample(wide, d, bz, r);
    chk("done_pulse", {63'b0, d}, 64'd0);
    chk("busy_end", {63'b0, bz}, 64'd0);
    if ({31'b0, r} !== exp) hold_bad++;
    chk("busy_cycles", 64'(busy_n), 64'(w + 1));
    chk("hold", 64'(hold_bad), 64'd0);
    if (wide) prev32 = exp[32:0];
    else prev8 = exp[32:0];
  endtask

  initial begin
    logic        d, bz, cr;
    logic [32:0] r;
    int          n_done;

    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    prev8  = '0;
    prev32 = '0;
    repeat (2) @(posedge clk);
    #1;
    sample(1'b0, d, bz, r);
    chk("reset_busy", {63'b0, bz}, 64'd0);
    chk("reset_done", {63'b0, d}, 64'd0);
    chk("reset_result8", {31'b0, r}, 64'd0);
    sample(1'b1, d, bz, r);
    chk("reset_result32", {31'b0, r}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(1'b0, 32'h0F, 32'h01, 1'b0, 1'b0);
    run_op(1'b0, 32'hFF, 32'h01, 1'b0, 1'b0);
    run_op(1'b0, 32'h00, 32'h00, 1'b1, 1'b0);
    run_op(1'b0, 32'h12, 32'h34, 1'b0, 1'b1);
    run_op(1'b0, 32'h5A, 32'h5A, 1'b0, 1'b0);

    // abort 3 edges into RUN with an asynchronous reset between edges
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h77, 32'h11, 1'b0);
    @(posedge clk); #1;
    garble(1'b0);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    sample(1'b0, d, bz, r);
    chk("abort_busy", {63'b0, bz}, 64'd0);
    chk("abort_done", {63'b0, d}, 64'd0);
    chk("abort_result", {31'b0, r}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    prev8  = '0;
    prev32 = '0;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      sample(1'b0, d, bz, r);
      if (d) n_done++;
    end
    chk("abort_no_done", 64'(n_done), 64'd0);
    run_op(1'b0, 32'h05, 32'h03, 1'b0, 1'b0);

    run_op(1'b0, 32'h7F, 32'h01, 1'b0, 1'b0);
    run_op(1'b0, 32'hFF, 32'hFF, 1'b0, 1'b0);
    run_op(1'b0, 32'h80, 32'h80, 1'b0, 1'b0);
    run_op(1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
    run_op(1'b1, 32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      cr = 1'($urandom_range(0, 1));
      run_op(1'b0, $urandom, $urandom, cr, 1'b0);
    end
    for (int i = 0; i < 1000; i++) begin
      cr = 1'($urandom_range(0, 1));
      run_op(1'b1, $urandom, $urandom, cr, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
